ucsbece154b_mem_arbiter: RTL and testbench

//  Shares one unified instruction/data memory port between the pipeline's fetch stage (IF) and memory stage (D).

---
 rtl/ucsbece154b_mem_arbiter_pkg.sv | 20 ++
 rtl/ucsbece154b_perf_counter.sv | 17 +
 rtl/ucsbece154b_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_mem_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM state
// encodings, starvation counter width and its saturating increment.
package ucsbece154b_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

    localparam int STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_SAT = 4'd15;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
        return (cnt == STARVE_SAT) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/ucsbece154b_perf_counter.sv
// 32-bit wrapping event counter with synchronous clear.
module ucsbece154b_perf_counter (
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count
);

    // Clear has priority over counting.
    always_ff @(posedge clk) begin
        if (clear)
            count <= 32'd0;
        else if (enable)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbiter sharing one unified memory port between fetch (IF) and memory (D).
// Data-first priority with an IF starvation guard; killed fetches are
// drained from the memory without returning data.
// Optional: define MEM_ARB_PERF_EN to add hierarchical performance counters
// (perf_if_grants, perf_d_grants, perf_conflicts, perf_kills, perf_busy_cycles).
module ucsbece154b_mem_arbiter
    import ucsbece154b_mem_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              if_ready_d, d_ready_d;
    logic [DATA_W-1:0] if_rdata_d, d_rdata_d;

    // A requester in its ready cycle is masked so its next request is seen fresh.
    logic if_elig, d_elig, starved;
    assign if_elig = if_req_i && !if_ready_o;
    assign d_elig  = d_req_i && !d_ready_o;
    assign starved = (starve_q >= STARVE_LIM);

    // State and starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state, arbitration and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_o;
        d_rdata_d   = d_rdata_o;
        case (state_q)
            ARB_IDLE: begin
                if (d_elig && (!if_elig || !starved)) begin
                    state_d     = ARB_GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    starve_d    = if_req_i ? starve_inc(starve_q) : '0;
                end else if (if_elig) begin
                    state_d     = ARB_GNT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end else if (!if_req_i) begin
                    starve_d = '0;
                end
            end
            ARB_GNT_I: begin
                if (mem_ack_i) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    // A kill coinciding with the ack swallows the data.
                    if (!if_kill_i) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end
                end else if (if_kill_i) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_GNT_D: begin
                if (mem_ack_i) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    d_rdata_d = mem_rdata_i;
                end
            end
            ARB_DRAIN: begin
                // Memory must still finish the abandoned fetch before reuse.
                if (mem_ack_i) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears everything so a dropped transfer leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ready_o  <= 1'b0;
            d_ready_o   <= 1'b0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
        end else begin
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            if_ready_o  <= if_ready_d;
            d_ready_o   <= d_ready_d;
            if_rdata_o  <= if_rdata_d;
            d_rdata_o   <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_conflicts;
    logic [31:0] perf_kills;
    logic [31:0] perf_busy_cycles;

    logic ev_if_grant, ev_d_grant, ev_conflict, ev_kill;
    assign ev_if_grant = (state_q == ARB_IDLE) && (state_d == ARB_GNT_I);
    assign ev_d_grant  = (state_q == ARB_IDLE) && (state_d == ARB_GNT_D);
    assign ev_conflict = (state_q == ARB_IDLE) && if_elig && d_elig;
    // Covers both a kill that forces DRAIN and a kill that lands on the ack.
    assign ev_kill     = (state_q == ARB_GNT_I) && if_kill_i;

    ucsbece154b_perf_counter u_perf_if_grants (
        .clk(clk), .clear(reset), .enable(ev_if_grant), .count(perf_if_grants));
    ucsbece154b_perf_counter u_perf_d_grants (
        .clk(clk), .clear(reset), .enable(ev_d_grant), .count(perf_d_grants));
    ucsbece154b_perf_counter u_perf_conflicts (
        .clk(clk), .clear(reset), .enable(ev_conflict), .count(perf_conflicts));
    ucsbece154b_perf_counter u_perf_kills (
        .clk(clk), .clear(reset), .enable(ev_kill), .count(perf_kills));
    ucsbece154b_perf_counter u_perf_busy (
        .clk(clk), .clear(reset), .enable(mem_req_o), .count(perf_busy_cycles));
`else
`endif

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Self-checking bench for the memory arbiter: directed scenarios plus
// randomized traffic, scored against a transaction-level port-owner model.
module tb_ucsbece154b_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_kill, d_req, d_we, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic          if_ready_o, d_ready_o, mem_req_o, mem_we_o;

    int total = 0;
    int bad = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    ucsbece154b_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_kill_i(if_kill),
        .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: who owns the memory port, what it must show, and
    // the responses owed to each requester.
    typedef struct { bit is_d; logic [DW-1:0] data; } exp_t;
    exp_t exp_q[$];

    localparam int OWN_NONE = 0, OWN_IF = 1, OWN_D = 2, OWN_DEAD = 3;
    int            m_own = OWN_NONE;
    int            m_starve = 0;
    logic          m_req = 0, m_we = 0, m_if_rdy = 0, m_d_rdy = 0;
    logic [AW-1:0] m_addr = 0;
    logic [DW-1:0] m_wdata = 0, m_if_data = 0, m_d_data = 0;
`ifdef MEM_ARB_PERF_EN
    int m_pf_if = 0, m_pf_d = 0, m_pf_conf = 0, m_pf_kill = 0, m_pf_busy = 0;
`endif

    always @(posedge clk) begin : model
        int own, stv;
        logic req, we, ir, dr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, ifd, dd;
        bit ie, de;
        own = m_own; stv = m_starve; req = m_req; we = m_we; addr = m_addr;
        wd = m_wdata; ifd = m_if_data; dd = m_d_data; ir = 0; dr = 0;
        ie = if_req && !m_if_rdy;
        de = d_req && !m_d_rdy;
`ifdef MEM_ARB_PERF_EN
        if (reset) begin
            m_pf_if <= 0; m_pf_d <= 0; m_pf_conf <= 0; m_pf_kill <= 0; m_pf_busy <= 0;
        end else begin
            if (m_req) m_pf_busy <= m_pf_busy + 1;
            if (own == OWN_NONE && ie && de) m_pf_conf <= m_pf_conf + 1;
            if (own == OWN_IF && if_kill) m_pf_kill <= m_pf_kill + 1;
            if (own == OWN_NONE && de && (!ie || stv < SMAX)) m_pf_d <= m_pf_d + 1;
            else if (own == OWN_NONE && ie) m_pf_if <= m_pf_if + 1;
        end
`endif
        if (reset) begin
            own = OWN_NONE; stv = 0; req = 0; we = 0; addr = 0; wd = 0; ifd = 0; dd = 0;
        end else begin
            case (own)
                OWN_NONE: begin
                    if (de && (!ie || stv < SMAX)) begin
                        own = OWN_D; req = 1; we = d_we; addr = d_addr; wd = d_wdata;
                        stv = if_req ? ((stv < 15) ? stv + 1 : 15) : 0;
                    end else if (ie) begin
                        own = OWN_IF; req = 1; we = 0; addr = if_addr; wd = 0; stv = 0;
                    end else if (!if_req) begin
                        stv = 0;
                    end
                end
                OWN_IF: begin
                    if (mem_ack) begin
                        own = OWN_NONE; req = 0;
                        if (!if_kill) begin
                            ir = 1; ifd = mem_rdata;
                            exp_q.push_back('{1'b0, mem_rdata});
                        end
                    end else if (if_kill) begin
                        own = OWN_DEAD;
                    end
                end
                OWN_D: begin
                    if (mem_ack) begin
                        own = OWN_NONE; req = 0; dr = 1; dd = mem_rdata;
                        exp_q.push_back('{1'b1, mem_rdata});
                    end
                end
                default: begin
                    if (mem_ack) begin
                        own = OWN_NONE; req = 0;
                    end
                end
            endcase
        end
        m_own <= own; m_starve <= stv; m_req <= req; m_we <= we; m_addr <= addr;
        m_wdata <= wd; m_if_data <= ifd; m_d_data <= dd; m_if_rdy <= ir; m_d_rdy <= dr;
    end

    // Monitor: compare visible outputs to the model and pop the scoreboard on each ready.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            chk("mem_req", mem_req_o, m_req);
            if (m_req) begin
                chk("mem_addr", mem_addr_o, m_addr);
                chk("mem_we", mem_we_o, m_we);
                chk("mem_wdata", mem_wdata_o, m_wdata);
            end
            chk("if_ready", if_ready_o, m_if_rdy);
            chk("d_ready", d_ready_o, m_d_rdy);
            chk("if_rdata_hold", if_rdata_o, m_if_data);
            chk("d_rdata_hold", d_rdata_o, m_d_data);
            if (if_ready_o || d_ready_o) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard: ready pulse with no response expected");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_requester", {63'd0, d_ready_o}, {63'd0, e.is_d});
                    chk("sb_rdata", d_ready_o ? d_rdata_o : if_rdata_o, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        if_req = 0; if_kill = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    endtask

    task automatic drive_random();
        mem_ack = ($urandom_range(0, 2) == 0) ? 1'b1 : (!mem_req_o && $urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
        if_kill = ($urandom_range(0, 11) == 0);
        if (if_ready_o || if_kill || !if_req) begin
            if_req = ($urandom_range(0, 2) != 0);
            if_addr = {$urandom} & 32'hFFFF_FFFC;
        end
        if (d_ready_o || !d_req) begin
            d_req = ($urandom_range(0, 2) != 0);
            d_we = $urandom_range(0, 1);
            d_addr = $urandom;
            d_wdata = $urandom;
        end
    endtask

    initial begin : stim
        int lat;
        reset = 1;
        idle_inputs();
        repeat (3) tick();
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_if_ready", if_ready_o, 0);
        chk("rst_d_ready", d_ready_o, 0);
        chk("rst_outs", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
        chk("rst_rdata", {if_rdata_o, d_rdata_o}, 0);
        reset = 0;
        mon_en = 1;
        tick();

        // 1: IF-only fetch, ack in second cycle of mem_req
        if_req = 1; if_addr = 32'h0000_0010;
        tick();
        chk("t1_req_c1", mem_req_o, 1);
        chk("t1_addr", mem_addr_o, 32'h10);
        tick();
        chk("t1_req_c2", mem_req_o, 1);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        tick();
        mem_ack = 0; if_req = 0;
        chk("t1_ready_c3", if_ready_o, 1);
        chk("t1_rdata", if_rdata_o, 32'h0050_0093);
        chk("t1_req_c3", mem_req_o, 0);
        tick();
        chk("t1_ready_c4", if_ready_o, 0);
        idle_inputs(); tick();

        // 2: conflict, D store first then IF
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t2_d_we", mem_we_o, 1);
        chk("t2_d_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("t2_d_addr", mem_addr_o, 32'h100);
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        chk("t2_d_ready", d_ready_o, 1);
        d_req = 0; mem_ack = 0;
        tick();
        chk("t2_if_granted", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 32'h200});
        mem_ack = 1; mem_rdata = 32'hCAFE_0001;
        tick();
        chk("t2_if_ready", if_ready_o, 1);
        idle_inputs(); tick(); tick();

        // 3: both requesters held; memory acks immediately
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 0; d_addr = 32'h400;
        for (int i = 0; i < 24; i++) begin
            tick();
            mem_ack = mem_req_o; mem_rdata = $urandom;
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick();
            mem_ack = mem_req_o;
        end
        idle_inputs(); tick();

        // 4: kill in first GNT_I cycle, ack three cycles later
        if_req = 1; if_addr = 32'h500;
        tick();
        if_kill = 1; if_req = 0;
        d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'h0BAD_F00D;
        tick();
        if_kill = 0;
        chk("t4_drain_c2", mem_req_o, 1);
        tick();
        chk("t4_drain_c3", mem_req_o, 1);
        tick();
        chk("t4_drain_c4", mem_req_o, 1);
        mem_ack = 1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 0;
        chk("t4_no_if_ready", if_ready_o, 0);
        chk("t4_req_low", mem_req_o, 0);
        tick();
        chk("t4_next_grant", {mem_req_o, mem_addr_o}, {1'b1, 32'h600});
        mem_ack = 1; mem_rdata = 32'h4444_0000;
        tick();
        chk("t4_d_ready", d_ready_o, 1);
        idle_inputs(); tick();

        // 5: kill and ack in the same cycle, pending D afterwards
        if_req = 1; if_addr = 32'h700;
        tick();
        if_kill = 1; if_req = 0; mem_ack = 1; mem_rdata = 32'h9999_9999;
        d_req = 1; d_we = 0; d_addr = 32'h800;
        tick();
        if_kill = 0; mem_ack = 0;
        chk("t5_no_if_ready", if_ready_o, 0);
        chk("t5_idle", mem_req_o, 0);
        tick();
        chk("t5_d_granted", {mem_req_o, mem_addr_o}, {1'b1, 32'h800});
        mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        idle_inputs(); tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive_random();
            tick();
        end
        idle_inputs();
        lat = 0;
        while ((mem_req_o || if_ready_o || d_ready_o) && lat < 50) begin
            mem_ack = 1; mem_rdata = $urandom;
            tick();
            lat++;
        end
        idle_inputs(); tick(); tick();
        chk("drain_timeout", {63'd0, lat >= 50}, 0);
        chk("drain_queue_empty", exp_q.size(), 0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_if_grants", dut.perf_if_grants, m_pf_if);
        chk("perf_d_grants", dut.perf_d_grants, m_pf_d);
        chk("perf_conflicts", dut.perf_conflicts, m_pf_conf);
        chk("perf_kills", dut.perf_kills, m_pf_kill);
        chk("perf_busy", dut.perf_busy_cycles, m_pf_busy);
`endif

        // 6: reset during GNT_D
        d_req = 1; d_we = 1; d_addr = 32'h900; d_wdata = 32'h1357_9BDF;
        tick();
        chk("t6_gnt_d", mem_req_o, 1);
        reset = 1;
        tick();
        reset = 0; d_req = 0;
        chk("t6_rst_req", mem_req_o, 0);
        chk("t6_rst_outs", {mem_we_o, mem_addr_o, mem_wdata_o}, 0);
        chk("t6_rst_ready", {if_ready_o, d_ready_o}, 0);
        chk("t6_rst_rdata", {if_rdata_o, d_rdata_o}, 0);
`ifdef MEM_ARB_PERF_EN
        chk("t6_perf_zero", {dut.perf_if_grants | dut.perf_d_grants | dut.perf_conflicts,
                             dut.perf_kills | dut.perf_busy_cycles}, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1;
            tick();
            chk("t6_no_d_ready", d_ready_o, 0);
        end
        idle_inputs(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
